// File: rtl/cache_bus_pkg.sv
// Shared definitions for the L1-cache memory-side bus: arbiter states and cache line geometry.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cache_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_RESP
    } arb_state_t;

    // reqtag bit that marks a read (line refill); a write gets a single response beat
    localparam int READ_BIT   = 12;
    localparam int LINE_BEATS = 8;

    function automatic int respBeats(input logic isRead, input int lineBeats);
        return isRead ? lineBeats : 1;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: the port other than lastGrant wins a tie.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic lastGrant,
    output logic vld,
    output logic winner
);

    assign vld    = req0 | req1;
    assign winner = (req0 & req1) ? ~lastGrant : req1;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Serialises I-cache (port 0) and D-cache (port 1) transactions onto one memory bus, round-robin.
// Latency: reqcyc at edge N gives reqack and bus_reqcyc after edge N; responses pass through combinationally.
// Backpressure: bus_reqack holds the issued request; the granted cache's respack drives bus_respack directly.
module cache_mem_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int TAG_W    = 13,
    parameter int BEATS    = cache_bus_pkg::LINE_BEATS,
    parameter int READ_BIT = cache_bus_pkg::READ_BIT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              c0_reqcyc,
    input  logic [ADDR_W-1:0] c0_req,
    input  logic [TAG_W-1:0]  c0_reqtag,
    output logic              c0_reqack,
    output logic              c0_respcyc,
    output logic [DATA_W-1:0] c0_resp,
    output logic [TAG_W-1:0]  c0_resptag,
    input  logic              c0_respack,

    input  logic              c1_reqcyc,
    input  logic [ADDR_W-1:0] c1_req,
    input  logic [TAG_W-1:0]  c1_reqtag,
    output logic              c1_reqack,
    output logic              c1_respcyc,
    output logic [DATA_W-1:0] c1_resp,
    output logic [TAG_W-1:0]  c1_resptag,
    input  logic              c1_respack,

    output logic              bus_reqcyc,
    output logic [ADDR_W-1:0] bus_req,
    output logic [TAG_W-1:0]  bus_reqtag,
    input  logic              bus_reqack,
    input  logic              bus_respcyc,
    input  logic [DATA_W-1:0] bus_resp,
    input  logic [TAG_W-1:0]  bus_resptag,
    output logic              bus_respack
);

    import cache_bus_pkg::*;

    localparam int CNT_W = $clog2(BEATS + 1);

    arb_state_t       state;
    logic             grant;
    logic             lastGrant;
    logic [CNT_W-1:0] beatCnt;
    logic [CNT_W-1:0] expBeats;

    logic             pickVld;
    logic             pickWinner;
    logic [TAG_W-1:0] winTag;
    logic             inResp;
    logic             grantedRespack;
    logic             beatDone;
    logic             lastBeat;

    rr_pick2 uPick (
        .req0      (c0_reqcyc),
        .req1      (c1_reqcyc),
        .lastGrant (lastGrant),
        .vld       (pickVld),
        .winner    (pickWinner)
    );

    assign winTag         = pickWinner ? c1_reqtag : c0_reqtag;
    assign inResp         = (state == ARB_RESP);
    assign grantedRespack = grant ? c1_respack : c0_respack;
    assign beatDone       = inResp & bus_respcyc & grantedRespack;
    assign lastBeat       = (beatCnt == expBeats - CNT_W'(1));

    // Response path is steered only in RESP, so stray bus beats in IDLE/ISSUE are never acked.
    assign bus_respack = inResp & grantedRespack;

    assign c0_respcyc = inResp & ~grant & bus_respcyc;
    assign c0_resp    = (inResp & ~grant) ? bus_resp : '0;
    assign c0_resptag = (inResp & ~grant) ? bus_resptag : '0;

    assign c1_respcyc = inResp & grant & bus_respcyc;
    assign c1_resp    = (inResp & grant) ? bus_resp : '0;
    assign c1_resptag = (inResp & grant) ? bus_resptag : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            grant      <= 1'b0;
            lastGrant  <= 1'b1;
            beatCnt    <= '0;
            expBeats   <= '0;
            c0_reqack  <= 1'b0;
            c1_reqack  <= 1'b0;
            bus_reqcyc <= 1'b0;
            bus_req    <= '0;
            bus_reqtag <= '0;
        end else begin
            c0_reqack <= 1'b0;
            c1_reqack <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (pickVld) begin
                        bus_req    <= pickWinner ? c1_req : c0_req;
                        bus_reqtag <= winTag;
                        bus_reqcyc <= 1'b1;
                        grant      <= pickWinner;
                        lastGrant  <= pickWinner;
                        expBeats   <= CNT_W'(respBeats(winTag[READ_BIT], BEATS));
                        beatCnt    <= '0;
                        c0_reqack  <= ~pickWinner;
                        c1_reqack  <= pickWinner;
                        state      <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (bus_reqack) begin
                        bus_reqcyc <= 1'b0;
                        state      <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    if (beatDone) begin
                        if (lastBeat) begin
                            beatCnt <= '0;
                            state   <= ARB_IDLE;
                        end else begin
                            beatCnt <= beatCnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
